// File: rtl/pe_array_param_pkg.sv
// -----------------------------------------------------------------------------
// pe_array_pkg
// Shared types and helpers for the parametrised systolic MAC array.
//   state_e      : drain sequencer states
//   chain_idx()  : linear position of PE(r,c) in the drain chain
//   count_width(): width of a counter able to hold 0..n inclusive
//   NUM_PE       : PE count of the default 3x3 configuration
// -----------------------------------------------------------------------------
package pe_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_ROWS = 3;
    localparam int DEF_COLS = 3;
    localparam int NUM_PE   = DEF_ROWS * DEF_COLS;

    // Row-major chain position; the drain shifts from low k towards high k.
    function automatic int chain_idx(input int r, input int c, input int cols);
        return (r * cols) + c;
    endfunction

    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pe_array_param_pe_cell.sv
// -----------------------------------------------------------------------------
// pe_cell
// One processing element of the systolic array.
//   clock, reset            : clock, async active-high reset
//   iact / iact_vld         : activation arriving from the left neighbour
//   weight / weight_vld     : weight arriving from the upper neighbour
//   mac_en                  : allow accumulation this cycle
//   fwd_en                  : allow valids to propagate to the neighbours
//   clear                   : zero the accumulator (wins over everything)
//   shift_en / acc_shift    : load the accumulator from the chain predecessor
//   iact_fwd(_vld)          : registered activation towards the right
//   weight_fwd(_vld)        : registered weight towards the bottom
//   acc                     : accumulator register
// -----------------------------------------------------------------------------
module pe_cell
    import pe_array_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] iact,
    input  logic              iact_vld,
    input  logic [DATA_W-1:0] weight,
    input  logic              weight_vld,
    input  logic              mac_en,
    input  logic              fwd_en,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [ACC_W-1:0]  acc_shift,
    output logic [DATA_W-1:0] iact_fwd,
    output logic              iact_fwd_vld,
    output logic [DATA_W-1:0] weight_fwd,
    output logic              weight_fwd_vld,
    output logic [ACC_W-1:0]  acc
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int EXT_W  = (ACC_W > PROD_W) ? ACC_W : PROD_W;

    logic [DATA_W-1:0]        iact_fwd_r;
    logic                     iact_fwd_vld_r;
    logic [DATA_W-1:0]        weight_fwd_r;
    logic                     weight_fwd_vld_r;
    logic [ACC_W-1:0]         acc_r;

    logic signed [PROD_W-1:0] iact_ext_s;
    logic signed [PROD_W-1:0] weight_ext_s;
    logic signed [PROD_W-1:0] prod_s;
    logic [ACC_W-1:0]         prod_acc_s;
    logic                     mac_fire_s;

    // Operands are widened first so the product keeps all 2*DATA_W bits;
    // it is then sign-extended past ACC_W if needed and cut back to ACC_W.
    assign iact_ext_s   = PROD_W'($signed(iact));
    assign weight_ext_s = PROD_W'($signed(weight));
    assign prod_s       = iact_ext_s * weight_ext_s;
    assign prod_acc_s   = ACC_W'(EXT_W'(prod_s));
    assign mac_fire_s   = mac_en && iact_vld && weight_vld;

    // Forwarding registers: one hop per cycle, valids dropped when fwd_en is low.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            iact_fwd_r       <= {DATA_W{1'b0}};
            iact_fwd_vld_r   <= 1'b0;
            weight_fwd_r     <= {DATA_W{1'b0}};
            weight_fwd_vld_r <= 1'b0;
        end else begin
            iact_fwd_vld_r   <= fwd_en && iact_vld;
            weight_fwd_vld_r <= fwd_en && weight_vld;
            if (iact_vld) begin
                iact_fwd_r <= iact;
            end else begin
                iact_fwd_r <= iact_fwd_r;
            end
            if (weight_vld) begin
                weight_fwd_r <= weight;
            end else begin
                weight_fwd_r <= weight_fwd_r;
            end
        end
    end

    // Accumulator: clear, then drain shift, then MAC; wraps modulo 2^ACC_W.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (clear) begin
            acc_r <= {ACC_W{1'b0}};
        end else if (shift_en) begin
            acc_r <= acc_shift;
        end else if (mac_fire_s) begin
            acc_r <= acc_r + prod_acc_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign iact_fwd       = iact_fwd_r;
    assign iact_fwd_vld   = iact_fwd_vld_r;
    assign weight_fwd     = weight_fwd_r;
    assign weight_fwd_vld = weight_fwd_vld_r;
    assign acc            = acc_r;

endmodule

// File: rtl/pe_array_param.sv
// -----------------------------------------------------------------------------
// pe_array_param
// ROWS x COLS output-stationary systolic MAC array with a drain sequencer.
// Activations travel right along rows, weights travel down columns, each PE
// accumulates locally. A drain snakes the accumulators out one word at a time,
// PE(ROWS-1,COLS-1) first and PE(0,0) last, through a valid/ready port.
//   clock, reset              : clock, async active-high reset
//   iact_in / iact_valid      : per-row activation entering column 0
//   weight_in / weight_valid  : per-column weight entering row 0
//   clear_acc                 : zero all accumulators (IDLE only)
//   start_drain               : begin a drain (IDLE only, loses to clear_acc)
//   data_out / out_valid      : drained accumulator word
//   out_ready                 : downstream accepts data_out
//   busy                      : sequencer not IDLE
//   drain_done                : one-cycle pulse after the last word is taken
// -----------------------------------------------------------------------------
module pe_array_param
    import pe_array_pkg::*;
#(
    parameter int ROWS   = 3,
    parameter int COLS   = 3,
    parameter int DATA_W = 32,
    parameter int ACC_W  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ROWS*DATA_W-1:0] iact_in,
    input  logic [ROWS-1:0]        iact_valid,
    input  logic [COLS*DATA_W-1:0] weight_in,
    input  logic [COLS-1:0]        weight_valid,
    input  logic                   clear_acc,
    input  logic                   start_drain,
    output logic [ACC_W-1:0]       data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   drain_done
);

    localparam int N_PE  = ROWS * COLS;
    localparam int CNT_W = count_width(N_PE);

    state_e             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               drain_done_r;

    logic               is_idle_s;
    logic               go_drain_s;
    logic               clear_s;
    logic               mac_en_s;
    logic               fwd_en_s;
    logic               shift_s;

    logic [ACC_W-1:0]   acc_s          [N_PE];
    logic [DATA_W-1:0]  iact_src_s     [ROWS][COLS];
    logic               iact_src_vld_s [ROWS][COLS];
    logic [DATA_W-1:0]  iact_fwd_s     [ROWS][COLS];
    logic               iact_fwd_vld_s [ROWS][COLS];
    logic [DATA_W-1:0]  wt_src_s       [ROWS][COLS];
    logic               wt_src_vld_s   [ROWS][COLS];
    logic [DATA_W-1:0]  wt_fwd_s       [ROWS][COLS];
    logic               wt_fwd_vld_s   [ROWS][COLS];

    // A MAC in the start_drain cycle still lands, but nothing in flight
    // survives into DRAIN: forwarding valids are dropped from that edge on.
    assign is_idle_s  = (state_r == IDLE);
    assign go_drain_s = is_idle_s && start_drain && !clear_acc;
    assign clear_s    = is_idle_s && clear_acc;
    assign mac_en_s   = is_idle_s;
    assign fwd_en_s   = is_idle_s && !go_drain_s;
    assign shift_s    = (state_r == DRAIN) && out_valid_r && out_ready;

    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            for (genvar c = 0; c < COLS; c++) begin : g_col
                localparam int K = chain_idx(r, c, COLS);
                logic [ACC_W-1:0] shift_in_s;

                if (c == 0) begin : g_iact_edge
                    assign iact_src_s[r][c]     = iact_in[r*DATA_W +: DATA_W];
                    assign iact_src_vld_s[r][c] = iact_valid[r];
                end else begin : g_iact_chain
                    assign iact_src_s[r][c]     = iact_fwd_s[r][c-1];
                    assign iact_src_vld_s[r][c] = iact_fwd_vld_s[r][c-1];
                end

                if (r == 0) begin : g_wt_edge
                    assign wt_src_s[r][c]     = weight_in[c*DATA_W +: DATA_W];
                    assign wt_src_vld_s[r][c] = weight_valid[c];
                end else begin : g_wt_chain
                    assign wt_src_s[r][c]     = wt_fwd_s[r-1][c];
                    assign wt_src_vld_s[r][c] = wt_fwd_vld_s[r-1][c];
                end

                // Head of the drain chain refills with zero.
                if (K == 0) begin : g_chain_head
                    assign shift_in_s = {ACC_W{1'b0}};
                end else begin : g_chain_link
                    assign shift_in_s = acc_s[K-1];
                end

                pe_cell #(
                    .DATA_W (DATA_W),
                    .ACC_W  (ACC_W)
                ) u_pe (
                    .clock          (clock),
                    .reset          (reset),
                    .iact           (iact_src_s[r][c]),
                    .iact_vld       (iact_src_vld_s[r][c]),
                    .weight         (wt_src_s[r][c]),
                    .weight_vld     (wt_src_vld_s[r][c]),
                    .mac_en         (mac_en_s),
                    .fwd_en         (fwd_en_s),
                    .clear          (clear_s),
                    .shift_en       (shift_s),
                    .acc_shift      (shift_in_s),
                    .iact_fwd       (iact_fwd_s[r][c]),
                    .iact_fwd_vld   (iact_fwd_vld_s[r][c]),
                    .weight_fwd     (wt_fwd_s[r][c]),
                    .weight_fwd_vld (wt_fwd_vld_s[r][c]),
                    .acc            (acc_s[K])
                );
            end

            // The last column's forwarded activation has no consumer.
            logic [DATA_W:0] unused_iact_s;
            assign unused_iact_s = {iact_fwd_s[r][COLS-1], iact_fwd_vld_s[r][COLS-1]};
        end

        for (genvar c = 0; c < COLS; c++) begin : g_wt_sink
            // The bottom row's forwarded weight has no consumer.
            logic [DATA_W:0] unused_wt_s;
            assign unused_wt_s = {wt_fwd_s[ROWS-1][c], wt_fwd_vld_s[ROWS-1][c]};
        end
    endgenerate

    // Drain sequencer: IDLE -> DRAIN (N_PE accepted words) -> DONE -> IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            drain_done_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    drain_done_r <= 1'b0;
                    if (go_drain_s) begin
                        state_r     <= DRAIN;
                        cnt_r       <= CNT_W'(N_PE);
                        out_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (shift_s) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                        if (cnt_r == CNT_W'(1)) begin
                            state_r      <= DONE;
                            out_valid_r  <= 1'b0;
                            drain_done_r <= 1'b1;
                        end else begin
                            state_r <= DRAIN;
                        end
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    busy_r       <= 1'b0;
                    drain_done_r <= 1'b0;
                    out_valid_r  <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    cnt_r        <= {CNT_W{1'b0}};
                    out_valid_r  <= 1'b0;
                    busy_r       <= 1'b0;
                    drain_done_r <= 1'b0;
                end
            endcase
        end
    end

    // The chain tail is itself a register; it only moves on an accepted
    // transfer, so data_out holds steady under backpressure.
    assign data_out   = out_valid_r ? acc_s[N_PE-1] : {ACC_W{1'b0}};
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign drain_done = drain_done_r;

endmodule
